// File: rtl/cache_req_scheduler_pkg.sv
// Shared types and defaults for the cache request scheduler.
// Holds the FSM state encoding and the default core count / address width.
package cache_req_scheduler_pkg;
    localparam int DEF_NUM_CORES = 4;
    localparam int DEF_ADDR_W    = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        PF_WAIT   = 3'd2,
        MEM_WAIT  = 3'd3,
        FILL_CMD  = 3'd4,
        FILL_WAIT = 3'd5,
        RESPOND   = 3'd6
    } state_t;

    // Index width, kept at least 1 so a single-core build still has a select bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/cache_req_scheduler_rr.sv
// Combinational round-robin pick: first set request at index >= ptr,
// wrapping modulo NUM_CORES.
module rr_select
    import cache_req_scheduler_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int IDX_W     = idx_w(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [IDX_W-1:0]     idx,
    output logic                 valid
);
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // Walk from the farthest offset down so the nearest request wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (sum >= (IDX_W + 1)'(NUM_CORES))
                sum = sum - (IDX_W + 1)'(NUM_CORES);
            cand = sum[IDX_W-1:0];
            if (req[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cache_req_scheduler.sv
// Serializes per-core cache accesses: cache lookup, then prefetcher, then a
// memory fetch and cache fill on a full miss; grants one core at a time.
module cache_req_scheduler
    import cache_req_scheduler_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    output logic [NUM_CORES-1:0]        core_grant,
    output logic                        core_hit,
    output logic                        start_cache,
    output logic [ADDR_W-1:0]           lookup_addr,
    input  logic                        done_cache,
    input  logic                        found_in_cache,
    input  logic                        done_prefetch,
    input  logic                        found_in_prefetcher,
    output logic                        mem_req,
    input  logic                        mem_ready,
    output logic                        update_cache_mem,
    input  logic                        updated_cache_mem,
    output logic                        busy,
    output logic [15:0]                 req_count,
    output logic [15:0]                 miss_count
);
    localparam int IDX_W = idx_w(NUM_CORES);

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] pick;
    logic             pick_vld;

    rr_select #(.NUM_CORES(NUM_CORES), .IDX_W(IDX_W)) u_rr (
        .req   (core_req),
        .ptr   (rr_ptr),
        .idx   (pick),
        .valid (pick_vld)
    );

    // All outputs are registered; grant/hit are loaded on entry to RESPOND
    // so they are high exactly while the FSM sits in RESPOND.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            sel              <= '0;
            lookup_addr      <= '0;
            core_grant       <= '0;
            core_hit         <= 1'b0;
            start_cache      <= 1'b0;
            mem_req          <= 1'b0;
            update_cache_mem <= 1'b0;
            busy             <= 1'b0;
            req_count        <= '0;
            miss_count       <= '0;
        end else begin
            start_cache      <= 1'b0;
            update_cache_mem <= 1'b0;
            core_grant       <= '0;
            core_hit         <= 1'b0;
            case (state)
                IDLE: if (pick_vld) begin
                    sel         <= pick;
                    lookup_addr <= core_addr[int'(pick)*ADDR_W +: ADDR_W];
                    start_cache <= 1'b1;
                    busy        <= 1'b1;
                    state       <= LOOKUP;
                end
                LOOKUP: if (done_cache) begin
                    if (found_in_cache) begin
                        core_grant <= NUM_CORES'(1) << sel;
                        core_hit   <= 1'b1;
                        state      <= RESPOND;
                    end else begin
                        state <= PF_WAIT;
                    end
                end
                PF_WAIT: if (done_prefetch) begin
                    if (found_in_prefetcher) begin
                        core_grant <= NUM_CORES'(1) << sel;
                        core_hit   <= 1'b1;
                        state      <= RESPOND;
                    end else begin
                        mem_req <= 1'b1;
                        state   <= MEM_WAIT;
                    end
                end
                MEM_WAIT: if (mem_ready) begin
                    mem_req          <= 1'b0;
                    update_cache_mem <= 1'b1;
                    state            <= FILL_CMD;
                end
                FILL_CMD: state <= FILL_WAIT;
                FILL_WAIT: if (updated_cache_mem) begin
                    if (miss_count != 16'hFFFF)
                        miss_count <= miss_count + 16'd1;
                    core_grant <= NUM_CORES'(1) << sel;
                    state      <= RESPOND;
                end
                RESPOND: begin
                    if (req_count != 16'hFFFF)
                        req_count <= req_count + 16'd1;
                    rr_ptr <= (sel == IDX_W'(NUM_CORES - 1)) ? '0 : sel + 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cache_req_scheduler.sv
// Directed bench for cache_req_scheduler: hit, prefetch hit, full miss,
// round-robin order, stray completions and reset abort.
module tb_cache_req_scheduler;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   core_req;
    logic [127:0] core_addr;
    logic [3:0]   core_grant;
    logic         core_hit, start_cache;
    logic [31:0]  lookup_addr;
    logic         done_cache, found_in_cache, done_prefetch, found_in_prefetcher;
    logic         mem_req, mem_ready, update_cache_mem, updated_cache_mem, busy;
    logic [15:0]  req_count, miss_count;

    int vectors = 0;
    int miscompares = 0;
    int grants = 0;
    int upd_pulses = 0;

    cache_req_scheduler #(.NUM_CORES(4), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .core_req(core_req), .core_addr(core_addr),
        .core_grant(core_grant), .core_hit(core_hit), .start_cache(start_cache),
        .lookup_addr(lookup_addr), .done_cache(done_cache),
        .found_in_cache(found_in_cache), .done_prefetch(done_prefetch),
        .found_in_prefetcher(found_in_prefetcher), .mem_req(mem_req),
        .mem_ready(mem_ready), .update_cache_mem(update_cache_mem),
        .updated_cache_mem(updated_cache_mem), .busy(busy),
        .req_count(req_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Pre-edge values are seen at posedge, so each count is one cycle.
    always @(posedge clk) begin
        if (core_grant != 4'b0) grants++;
        if (update_cache_mem) upd_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (start_cache !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start"}, 32'(start_cache), 32'd1);
    endtask

    task automatic serve_hit(input int exp_idx, input string tag);
        wait_start(tag);
        @(negedge clk); done_cache = 1'b1; found_in_cache = 1'b1;
        @(negedge clk); done_cache = 1'b0; found_in_cache = 1'b0;
        check({tag, "_grant"}, 32'(core_grant), 32'(1 << exp_idx));
        check({tag, "_hit"}, 32'(core_hit), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int g0;
        int u0;
        rst_n = 1'b0; core_req = '0; core_addr = '0;
        done_cache = 0; found_in_cache = 0; done_prefetch = 0; found_in_prefetcher = 0;
        mem_ready = 0; updated_cache_mem = 0;
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(core_grant), 0);
        check("rst_hit", 32'(core_hit), 0);
        check("rst_start", 32'(start_cache), 0);
        check("rst_memreq", 32'(mem_req), 0);
        check("rst_update", 32'(update_cache_mem), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_reqcnt", 32'(req_count), 0);
        check("rst_misscnt", 32'(miss_count), 0);
        check("rst_addr", lookup_addr, 0);
        rst_n = 1'b1;

        // Single hit on core 0, done the cycle after start.
        core_addr[31:0] = 32'h0000_1230; core_req = 4'b0001;
        @(negedge clk);
        check("h0_start", 32'(start_cache), 1);
        check("h0_busy", 32'(busy), 1);
        check("h0_addr", lookup_addr, 32'h0000_1230);
        @(negedge clk);
        check("h0_start_pulse", 32'(start_cache), 0);
        check("h0_nogrant", 32'(core_grant), 0);
        done_cache = 1'b1; found_in_cache = 1'b1;
        @(negedge clk);
        done_cache = 1'b0; found_in_cache = 1'b0;
        check("h0_grant", 32'(core_grant), 32'b0001);
        check("h0_hit", 32'(core_hit), 1);
        check("h0_addr_hold", lookup_addr, 32'h0000_1230);
        core_req = 4'b0000;
        @(negedge clk);
        check("h0_grant_pulse", 32'(core_grant), 0);
        check("h0_reqcnt", 32'(req_count), 1);
        check("h0_idle", 32'(busy), 0);

        // Round robin with all cores requesting continuously.
        do_reset();
        for (int i = 0; i < 4; i++) core_addr[i*32 +: 32] = 32'h1000 * (i + 1);
        core_req = 4'b1111;
        for (int i = 0; i < 5; i++) serve_hit(i % 4, $sformatf("rr%0d", i));
        core_req = 4'b0000;
        @(negedge clk);
        check("rr_reqcnt", 32'(req_count), 5);

        // Cache miss, prefetcher hit on core 2 (rr_ptr now 1).
        core_addr[64 +: 32] = 32'h0000_ABC0; core_req = 4'b0100;
        wait_start("pf");
        check("pf_addr", lookup_addr, 32'h0000_ABC0);
        @(negedge clk); done_cache = 1'b1; found_in_cache = 1'b0;
        @(negedge clk); done_cache = 1'b0;
        check("pf_wait_nogrant", 32'(core_grant), 0);
        check("pf_wait_busy", 32'(busy), 1);
        check("pf_wait_memreq", 32'(mem_req), 0);
        done_prefetch = 1'b1; found_in_prefetcher = 1'b1;
        @(negedge clk); done_prefetch = 1'b0; found_in_prefetcher = 1'b0;
        check("pf_grant", 32'(core_grant), 32'b0100);
        check("pf_hit", 32'(core_hit), 1);
        check("pf_memreq", 32'(mem_req), 0);
        core_req = 4'b0000;
        @(negedge clk);
        check("pf_misscnt", 32'(miss_count), 0);
        check("pf_reqcnt", 32'(req_count), 6);

        // Full miss on core 3: memory ready after 10 cycles, fill ack 2 later.
        core_addr[96 +: 32] = 32'hDEAD_BEE0; core_req = 4'b1000;
        u0 = upd_pulses;
        wait_start("mm");
        @(negedge clk); done_cache = 1'b1; found_in_cache = 1'b0;
        @(negedge clk); done_cache = 1'b0; done_prefetch = 1'b1; found_in_prefetcher = 1'b0;
        @(negedge clk); done_prefetch = 1'b0;
        cnt = 0;
        while (mem_req === 1'b1 && cnt < 50) begin
            cnt++;
            if (cnt == 10) mem_ready = 1'b1;
            @(negedge clk);
            mem_ready = 1'b0;
        end
        check("mm_memreq_cycles", 32'(cnt), 10);
        check("mm_fill_cmd", 32'(update_cache_mem), 1);
        @(negedge clk);
        check("mm_fill_pulse", 32'(update_cache_mem), 0);
        @(negedge clk); updated_cache_mem = 1'b1;
        @(negedge clk); updated_cache_mem = 1'b0;
        check("mm_grant", 32'(core_grant), 32'b1000);
        check("mm_hit", 32'(core_hit), 0);
        check("mm_misscnt", 32'(miss_count), 1);
        check("mm_addr", lookup_addr, 32'hDEAD_BEE0);
        core_req = 4'b0000;
        @(negedge clk);
        check("mm_reqcnt", 32'(req_count), 7);
        check("mm_upd_pulses", 32'(upd_pulses - u0), 1);

        // Stray done_cache while idle.
        g0 = grants;
        done_cache = 1'b1; found_in_cache = 1'b1;
        @(negedge clk); done_cache = 1'b0; found_in_cache = 1'b0;
        check("stray_busy", 32'(busy), 0);
        check("stray_start", 32'(start_cache), 0);
        check("stray_grant", 32'(core_grant), 0);
        @(negedge clk);
        check("stray_grants", 32'(grants - g0), 0);

        // Hit on core 1 leaves rr_ptr at 2 before the reset-abort case.
        core_addr[32 +: 32] = 32'h0000_5550; core_req = 4'b0010;
        serve_hit(1, "c1");
        core_req = 4'b0000;
        @(negedge clk);
        check("c1_reqcnt", 32'(req_count), 8);

        // Reset during MEM_WAIT aborts the transaction.
        core_req = 4'b0110;
        wait_start("ab");
        check("ab_sel_addr", lookup_addr, 32'h0000_ABC0);
        @(negedge clk); done_cache = 1'b1; found_in_cache = 1'b0;
        @(negedge clk); done_cache = 1'b0; done_prefetch = 1'b1; found_in_prefetcher = 1'b0;
        @(negedge clk); done_prefetch = 1'b0;
        check("ab_memreq", 32'(mem_req), 1);
        g0 = grants;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("ab_memreq_drop", 32'(mem_req), 0);
        check("ab_busy", 32'(busy), 0);
        check("ab_reqcnt", 32'(req_count), 0);
        check("ab_misscnt", 32'(miss_count), 0);
        check("ab_addr", lookup_addr, 0);
        rst_n = 1'b1;
        check("ab_nogrant", 32'(grants - g0), 0);
        wait_start("ab2");
        check("ab2_addr", lookup_addr, 32'h0000_5550);
        serve_hit(1, "ab2");
        core_req = 4'b0000;
        @(negedge clk);
        check("ab2_reqcnt", 32'(req_count), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cache_req_scheduler.md
CACHE_REQ_SCHEDULER -- requirements
Module: cache_req_scheduler

Interface
REQ-001 Parameters SHALL be:
- NUM_CORES, default 4, number of requesting cores.
- ADDR_W, default 32, address width.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- core_req  in  NUM_CORES  per-core access request; held high until that core's grant.
- core_addr  in  NUM_CORES*ADDR_W  packed addresses; core i at bits [i*ADDR_W +: ADDR_W].
- core_grant  out  NUM_CORES  one-hot completion pulse.
- core_hit  out  1  result qualifying core_grant (1 = cache or prefetcher hit).
- start_cache  out  1  one-cycle lookup start to the cache find/update block.
- lookup_addr  out  ADDR_W  address of the transaction in service; stable from start_cache through grant.
- done_cache, found_in_cache  in  1 each  cache lookup completion and result.
- done_prefetch, found_in_prefetcher  in  1 each  prefetcher lookup completion and result.
- mem_req  out  1  level request for a block from memory.
- mem_ready  in  1  memory block available.
- update_cache_mem  out  1  one-cycle fill command.
- updated_cache_mem  in  1  fill acknowledge.
- busy  out  1  high in any state other than IDLE.
- req_count, miss_count  out  16 each  serviced-transaction and full-miss counters.

Function
REQ-003 The FSM SHALL have seven states: IDLE, LOOKUP, PF_WAIT, MEM_WAIT, FILL_CMD, FILL_WAIT, RESPOND.
REQ-004 In IDLE with any core_req bit high, the block SHALL take the following actions in the same cycle:
- select a core round-robin: the first set bit at index >= rr_ptr, wrapping modulo NUM_CORES;
- latch that core's address into lookup_addr;
- register the selected index;
- assert start_cache for exactly one cycle;
- enter LOOKUP.
REQ-005 In LOOKUP, the block SHALL wait for done_cache. With found_in_cache=1 it goes to RESPOND with hit=1; with found_in_cache=0 it goes to PF_WAIT.
REQ-006 In PF_WAIT, the block SHALL wait for done_prefetch. With found_in_prefetcher=1 it goes to RESPOND with hit=1; otherwise it goes to MEM_WAIT.
REQ-007 In MEM_WAIT, mem_req SHALL be held high until mem_ready is sampled high, then the block goes to FILL_CMD.
REQ-008 In FILL_CMD, the block SHALL pulse update_cache_mem for one cycle and go to FILL_WAIT. In FILL_WAIT it waits for updated_cache_mem, increments miss_count, and goes to RESPOND with hit=0.
REQ-009 In RESPOND, the block SHALL do all of the following for exactly one cycle, then return to IDLE:
- drive core_grant[sel]=1 and core_hit=hit;
- increment req_count;
- set rr_ptr=(sel+1) mod NUM_CORES.
REQ-010 Minimum latency from core_req rising (in IDLE) to core_grant SHALL be 3 cycles for a hit that returns done_cache the cycle after start_cache.
REQ-011 Completion inputs (done_cache, done_prefetch, mem_ready, updated_cache_mem) SHALL be ignored outside their own wait state.
REQ-012 core_req changes while busy SHALL have no effect on the transaction in service. A core that is still requesting in the cycle after its grant SHALL be treated as a new request.
REQ-013 Counters SHALL saturate at 16'hFFFF.
REQ-014 done_cache and found_in_cache arriving together SHALL be evaluated in the same cycle; found_in_cache is meaningful only when done_cache=1.

Reset
REQ-015 With rst_n=0 at a clock edge, the block SHALL:
- enter IDLE;
- set rr_ptr=0, lookup_addr=0, sel=0 and both counters to 0;
- drive all outputs to 0.
REQ-016 Reset asserted mid-transaction SHALL abort it with no grant and no counter update. mem_req SHALL drop on the next edge.

Structure
REQ-017 A shared package SHALL hold the FSM state encoding (3-bit) and the default NUM_CORES and ADDR_W constants.
REQ-018 The round-robin selector SHALL be a combinational sub-module, rr_select (inputs: request vector and rr_ptr; outputs: index and valid).

Verification
REQ-019 Reset, then core_req=4'b0001, addr 0x0000_1230, done_cache+found_in_cache the cycle after start_cache -> lookup_addr=0x0000_1230; core_grant=4'b0001 with core_hit=1 three cycles after request; req_count=1.
REQ-020 core_req=4'b1111 held continuously, all hits -> grant order 0,1,2,3,0; no core granted twice before every other requesting core is granted once.
REQ-021 Cache miss with prefetcher hit -> PF_WAIT visited; no mem_req; core_hit=1; miss_count unchanged.
REQ-022 Cache and prefetcher miss, mem_ready after 10 cycles, updated_cache_mem 2 cycles after the fill command -> mem_req high for exactly 10 cycles; one update_cache_mem pulse; core_hit=0; miss_count=1.
REQ-023 rst_n=0 during MEM_WAIT -> no grant; mem_req=0 after the next edge; counters=0; the next request begins from rr_ptr=0.
REQ-024 Stray done_cache pulse while in IDLE -> no state change and no grant.
